pipe_mul: RTL and testbench
===========================

Name: pipe_mul

Overview:
- Parametrised, pipelined, handshaked unsigned multiplier.
- Next generation of the single-shot multiplier in the multpool.
- Splits operand b into NSLICE slices and accumulates one partial product per pipeline stage, so a new operand pair can be accepted every cycle.
- Adds valid/ready backpressure, a passthrough tag, and four output modes: full, low half, high half, square.
- Sits between the multpool scheduler and the modular-reduction units.

Parameters:
- NBITS, 128: operand width; must be divisible by NSLICE.
- NSLICE, 4: number of b slices, equal to the number of accumulate stages (≥1). Slice width SW = NBITS/NSLICE.
- TAGW, 4: width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and mode are valid.
- in_ready  out  1  block can accept this cycle.
- a  in  NBITS  multiplicand.
- b  in  NBITS  multiplier; ignored in square mode.
- mode  in  2  0=FULL, 1=LO, 2=HI, 3=SQR.
- tag_in  in  TAGW  returned unchanged with the result.
- out_valid  out  1  y/tag_out valid.
- out_ready  in  1  consumer accepts the result.
- y  out  2*NBITS  result.
- tag_out  out  TAGW  tag of the current result.
- busy  out  1  any pipeline stage holds a valid operation.

Behaviour:
- Reset: the one clock is clk. Reset is rst, synchronous and active-high; all logic is evaluated only on the rising edge of clk.
  - While rst=1 at an edge, all stage valids, accumulators, operands, tags and mode registers clear to 0.
  - Resulting outputs: out_valid=0, y=0, tag_out=0, busy=0.
  - in_ready=0 while rst=1.
  - Reset mid-operation discards all in-flight operations; nothing is emitted afterwards.
- Handshake:
  - accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - stall = out_valid & ~out_ready; in_ready = ~stall & ~rst.
  - While stalled, every stage register holds; y and tag_out stay stable until accepted.
- Pipeline: stage 0 plus stages 1..NSLICE.
  - Stage 0 registers a, b_eff, mode and tag on accept. b_eff = a when mode=SQR, else b.
  - If ~stall and ~accept, the stage 0 valid clears (bubble).
  - Stage k (1..NSLICE) computes acc_k = acc_{k-1} + (a * b_eff[k*SW-1:(k-1)*SW]) << ((k-1)*SW), with acc_0 = 0. Accumulators are 2*NBITS wide, with no overflow.
  - a, b_eff, mode and tag advance with each stage.
  - Bubbles are not collapsed: the pipeline advances as a whole whenever ~stall.
- Latency:
  - out_valid rises exactly NSLICE edges after the accepting edge (4 at the default).
  - Throughput is 1 op/cycle with out_ready=1.
  - Results are in order.
- Output mode is applied on the final stage register:
  - FULL and SQR: y = acc_NSLICE.
  - LO: y = {NBITS zeros, acc[NBITS-1:0]}.
  - HI: y = {NBITS zeros, acc[2*NBITS-1:NBITS]}.
- Simultaneous events:
  - Output transfer and input accept in the same cycle are legal; the pipeline advances.
  - A stall with in_valid=1 refuses the input (in_ready=0); the source must hold it.
- Boundary cases:
  - NSLICE=1 gives a single accumulate stage with latency 1.
  - busy = OR of all stage valids, including the output stage.
- Illegal parameter combinations (NBITS % NSLICE ≠ 0) stop elaboration with an error.

Decomposition:
- Shared package mul_pkg: MODE_FULL/LO/HI/SQR localparams and the mode width.
- Sub-module mul_slice_stage: one stage register (valid, a, b_eff, mode, tag, acc) with hold-on-stall, plus the slice multiply-add. Instantiated NSLICE times in a generate loop.
- The top level holds stage 0, the handshake and the output mode mux.

Test Plan:
- Directed scenarios run with NBITS=16, NSLICE=4, TAGW=4 unless stated.
- FULL, no stall: a=0xFFFF, b=0xFFFF, tag=5, accepted at edge t → y=0xFFFE0001, tag_out=5, out_valid first high after edge t+4.
- LO/HI: a=0xFFFF, b=0xFFFF, mode=LO → y=0x00000001; mode=HI → y=0x0000FFFE.
- SQR: a=0x1234, b=0xDEAD, mode=SQR → y=0x014B5A90; b is ignored.
- Back-to-back with stall:
  - Stimulus: 6 consecutive ops (a=i+1, b=3, tags 0..5), out_ready low for 3 cycles after the first result.
  - Required: in_ready=0 during the stall, y held stable, results 3,6,9,12,15,18 in order with matching tags, no drops or duplicates.
- Reset mid-flight: 3 ops accepted, then rst=1 for one cycle → out_valid=0, y=0, busy=0, and no stale result ever appears afterwards.
- NSLICE=1 variant: a=0x00FF, b=0x0100 → y=0x0000FF00 one edge after accept; random compare against a reference model for 10k ops per mode.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier: output mode encoding.
package mul_pkg;

    localparam int unsigned MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_FULL = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_LO   = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_HI   = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_SQR  = MODE_W'(3);

endpackage

// File: rtl/pipe_mul_if.sv
// Operand/result handshake bundle between the multpool scheduler and pipe_mul.
interface pipe_mul_if #(
    parameter int unsigned NBITS = 128,
    parameter int unsigned TAGW  = 4
);
    import mul_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [NBITS-1:0]     a;
    logic [NBITS-1:0]     b;
    logic [MODE_W-1:0]    mode;
    logic [TAGW-1:0]      tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*NBITS-1:0]   y;
    logic [TAGW-1:0]      tag_out;
    logic                 busy;

    modport master (
        output in_valid, a, b, mode, tag_in, out_ready,
        input  in_ready, out_valid, y, tag_out, busy
    );

    modport slave (
        input  in_valid, a, b, mode, tag_in, out_ready,
        output in_ready, out_valid, y, tag_out, busy
    );

endinterface

// File: rtl/mul_slice_stage.sv
// One accumulate stage: adds a * (slice K of b_eff), shifted into place, to the
// running product and carries the operation's context along. Holds when en=0.
module mul_slice_stage
    import mul_pkg::*;
#(
    parameter int unsigned NBITS = 128,
    parameter int unsigned SW    = 32,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned K     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 prev_valid,
    input  logic [NBITS-1:0]     prev_a,
    input  logic [NBITS-1:0]     prev_b,
    input  logic [MODE_W-1:0]    prev_mode,
    input  logic [TAGW-1:0]      prev_tag,
    input  logic [2*NBITS-1:0]   prev_acc,
    output logic                 valid,
    output logic [NBITS-1:0]     a,
    output logic [NBITS-1:0]     b,
    output logic [MODE_W-1:0]    mode,
    output logic [TAGW-1:0]      tag,
    output logic [2*NBITS-1:0]   acc
);

    localparam int unsigned AW  = 2 * NBITS;
    localparam int unsigned PW  = NBITS + SW;
    localparam int unsigned LSB = (K - 1) * SW;

    logic [SW-1:0] slice_c;
    logic [PW-1:0] pp_c;
    logic [AW-1:0] sum_c;

    // Partial product of the full multiplicand with this stage's slice of b.
    assign slice_c = prev_b[LSB +: SW];
    assign pp_c    = PW'(prev_a) * PW'(slice_c);
    assign sum_c   = prev_acc + (AW'(pp_c) << LSB);

    // Stage register: advances with the whole pipeline, holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            mode  <= '0;
            tag   <= '0;
            acc   <= '0;
        end else if (en) begin
            valid <= prev_valid;
            a     <= prev_a;
            b     <= prev_b;
            mode  <= prev_mode;
            tag   <= prev_tag;
            acc   <= sum_c;
        end
    end

endmodule

// File: rtl/pipe_mul.sv
// Pipelined, handshaked unsigned multiplier. Stage 0 captures operands, then
// NSLICE accumulate stages each add one slice of b; the last stage is the output.
module pipe_mul
    import mul_pkg::*;
#(
    parameter int unsigned NBITS  = 128,
    parameter int unsigned NSLICE = 4,
    parameter int unsigned TAGW   = 4
) (
    input  logic       clk,
    input  logic       rst,
    pipe_mul_if.slave  bus
);

    localparam int unsigned NS_SAFE = (NSLICE == 0) ? 1 : NSLICE;
    localparam int unsigned SW      = NBITS / NS_SAFE;
    localparam int unsigned AW      = 2 * NBITS;

    // Reject slice counts that do not evenly divide the operand.
    if (NSLICE == 0 || (NBITS % NS_SAFE) != 0) begin : g_bad_param
        $error("pipe_mul: NBITS (%0d) must be a nonzero multiple of NSLICE (%0d)", NBITS, NSLICE);
    end

    logic                 s0_valid;
    logic [NBITS-1:0]     s0_a;
    logic [NBITS-1:0]     s0_b;
    logic [MODE_W-1:0]    s0_mode;
    logic [TAGW-1:0]      s0_tag;

    logic                 st_valid [NSLICE+1];
    logic [NBITS-1:0]     st_a     [NSLICE+1];
    logic [NBITS-1:0]     st_b     [NSLICE+1];
    logic [MODE_W-1:0]    st_mode  [NSLICE+1];
    logic [TAGW-1:0]      st_tag   [NSLICE+1];
    logic [AW-1:0]        st_acc   [NSLICE+1];

    logic stall_c;
    logic adv_c;
    logic accept_c;

    // Backpressure: only a held, unaccepted result stalls the pipeline.
    assign stall_c      = st_valid[NSLICE] & ~bus.out_ready;
    assign adv_c        = ~stall_c;
    assign bus.in_ready = ~stall_c & ~rst;
    assign accept_c     = bus.in_valid & bus.in_ready;

    // Stage 0: capture operands; square mode substitutes a for b.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_mode  <= '0;
            s0_tag   <= '0;
        end else if (adv_c) begin
            s0_valid <= accept_c;
            if (accept_c) begin
                s0_a    <= bus.a;
                s0_b    <= (bus.mode == MODE_SQR) ? bus.a : bus.b;
                s0_mode <= bus.mode;
                s0_tag  <= bus.tag_in;
            end
        end
    end

    assign st_valid[0] = s0_valid;
    assign st_a[0]     = s0_a;
    assign st_b[0]     = s0_b;
    assign st_mode[0]  = s0_mode;
    assign st_tag[0]   = s0_tag;
    assign st_acc[0]   = '0;

    for (genvar k = 1; k <= NSLICE; k++) begin : g_stage
        mul_slice_stage #(
            .NBITS (NBITS),
            .SW    (SW),
            .TAGW  (TAGW),
            .K     (k)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (adv_c),
            .prev_valid (st_valid[k-1]),
            .prev_a     (st_a[k-1]),
            .prev_b     (st_b[k-1]),
            .prev_mode  (st_mode[k-1]),
            .prev_tag   (st_tag[k-1]),
            .prev_acc   (st_acc[k-1]),
            .valid      (st_valid[k]),
            .a          (st_a[k]),
            .b          (st_b[k]),
            .mode       (st_mode[k]),
            .tag        (st_tag[k]),
            .acc        (st_acc[k])
        );
    end

    assign bus.out_valid = st_valid[NSLICE];
    assign bus.tag_out   = st_tag[NSLICE];

    // Output mode select on the final stage register.
    always_comb begin
        bus.y = st_acc[NSLICE];
        case (st_mode[NSLICE])
            MODE_LO: bus.y = {NBITS'(0), st_acc[NSLICE][NBITS-1:0]};
            MODE_HI: bus.y = {NBITS'(0), st_acc[NSLICE][AW-1:NBITS]};
            default: ;
        endcase
    end

    // Busy whenever any stage, including the output stage, holds an operation.
    always_comb begin
        bus.busy = 1'b0;
        for (int unsigned k = 0; k <= NSLICE; k++) begin
            bus.busy = bus.busy | st_valid[k];
        end
    end

endmodule

// File: tb/tb_pipe_mul.sv
// Testbench for pipe_mul: 16-bit operands, NSLICE=4 and NSLICE=1 instances,
// directed scenarios plus randomized traffic against a product-level model.
module tb_pipe_mul;
    import mul_pkg::*;

    logic        clk;
    logic        rst;
    logic        dsel;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic [3:0]  tag_in;

    int checks;
    int errors;

    pipe_mul_if #(.NBITS(16), .TAGW(4)) bus4 ();
    pipe_mul_if #(.NBITS(16), .TAGW(4)) bus1 ();

    pipe_mul #(.NBITS(16), .NSLICE(4), .TAGW(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    pipe_mul #(.NBITS(16), .NSLICE(1), .TAGW(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus4.in_valid  = in_valid & ~dsel;
    assign bus1.in_valid  = in_valid & dsel;
    assign bus4.a         = a;
    assign bus1.a         = a;
    assign bus4.b         = b;
    assign bus1.b         = b;
    assign bus4.mode      = mode;
    assign bus1.mode      = mode;
    assign bus4.tag_in    = tag_in;
    assign bus1.tag_in    = tag_in;
    assign bus4.out_ready = out_ready;
    assign bus1.out_ready = out_ready;

    logic        ir;
    logic        ov;
    logic        bsy;
    logic [31:0] yo;
    logic [3:0]  to;

    assign ir  = dsel ? bus1.in_ready  : bus4.in_ready;
    assign ov  = dsel ? bus1.out_valid : bus4.out_valid;
    assign bsy = dsel ? bus1.busy      : bus4.busy;
    assign yo  = dsel ? bus1.y         : bus4.y;
    assign to  = dsel ? bus1.tag_out   : bus4.tag_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 32-bit product, then mode selection.
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] z,
                                            input logic [1:0] m);
        logic [31:0] p;
        p = 32'(x) * 32'((m == MODE_SQR) ? x : z);
        case (m)
            MODE_LO: return {16'h0000, p[15:0]};
            MODE_HI: return {16'h0000, p[31:16]};
            default: return p;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid4 got %b want 0", bus4.out_valid); end
        checks++; if (bus4.y !== 32'h0) begin errors++; $display("FAIL reset_y4 got %h want 0", bus4.y); end
        checks++; if (bus4.tag_out !== 4'h0) begin errors++; $display("FAIL reset_tag4 got %h want 0", bus4.tag_out); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy4 got %b want 0", bus4.busy); end
        checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready4 got %b want 0", bus4.in_ready); end
        checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid1 got %b want 0", bus1.out_valid); end
        checks++; if (bus1.y !== 32'h0) begin errors++; $display("FAIL reset_y1 got %h want 0", bus1.y); end
        checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready1 got %b want 0", bus1.in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready4 got %b want 1", bus4.in_ready); end
    endtask

    // Single operation: exact latency, result, tag, and empty pipe afterwards.
    task automatic test_latency(input logic s, input int lat, input logic [15:0] ta,
                                input logic [15:0] tbv, input logic [1:0] tm,
                                input logic [3:0] tt, input logic [31:0] ey, input string nm);
        @(posedge clk); #1;
        dsel = s; out_ready = 1'b1;
        a = ta; b = tbv; mode = tm; tag_in = tt; in_valid = 1'b1;
        #1;
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL %s_in_ready got %b want 1", nm, ir); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (ov !== (k == lat)) begin errors++; $display("FAIL %s_out_valid_edge%0d got %b want %b", nm, k, ov, (k == lat)); end
        end
        checks++; if (yo !== ey) begin errors++; $display("FAIL %s_y got %h want %h", nm, yo, ey); end
        checks++; if (to !== tt) begin errors++; $display("FAIL %s_tag got %h want %h", nm, to, tt); end
        @(posedge clk); #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL %s_drained got %b want 0", nm, ov); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b want 0", nm, bsy); end
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        int   stall_left = 0;
        logic first_seen = 1'b0;
        logic held_v = 1'b0;
        logic [31:0] hy = '0;
        logic [3:0]  ht = '0;
        @(posedge clk); #1;
        dsel = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        while (got < 6 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (held_v) begin
                checks++;
                if (yo !== hy || to !== ht) begin errors++; $display("FAIL b2b_hold got %h/%h want %h/%h", yo, to, hy, ht); end
            end
            if (ov && !first_seen) begin first_seen = 1'b1; stall_left = 3; end
            if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
            else out_ready = 1'b1;
            if (sent < 6) begin
                a = 16'(sent + 1); b = 16'd3; mode = MODE_FULL; tag_in = 4'(sent); in_valid = 1'b1;
            end else in_valid = 1'b0;
            #1;
            if (ov && !out_ready) begin
                checks++;
                if (ir !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready got %b want 0", ir); end
            end
            if (in_valid && ir) sent++;
            if (ov && out_ready) begin
                checks++;
                if (yo !== 32'(3 * (got + 1)) || to !== 4'(got))
                    begin errors++; $display("FAIL b2b_result%0d got %h/%h want %h/%h", got, yo, to, 32'(3 * (got + 1)), 4'(got)); end
                got++;
            end
            held_v = ov && !out_ready; hy = yo; ht = to;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 6) begin errors++; $display("FAIL b2b_count got %0d want 6", got); end
        @(posedge clk); #1;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got %b want 0", ov); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %b want 0", bsy); end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        dsel = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'(i + 7); b = 16'h0101; mode = MODE_FULL; tag_in = 4'(i + 9); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", bsy); end
        rst = 1'b1;
        #1;
        checks++; if (ir !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", ir); end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", ov); end
        checks++; if (yo !== 32'h0) begin errors++; $display("FAIL midrst_y got %h want 0", yo); end
        checks++; if (to !== 4'h0) begin errors++; $display("FAIL midrst_tag got %h want 0", to); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bsy); end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ov !== 1'b0 || bsy !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle%0d got %b/%b want 0/0", i, ov, bsy); end
        end
    endtask

    // Random traffic with random backpressure; fmode < 0 picks a random mode per op.
    task automatic test_random(input logic s, input int nops, input int fmode, input string nm);
        logic [31:0] qy[$];
        logic [3:0]  qt[$];
        logic [31:0] ey;
        logic [3:0]  et;
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        logic last_acc = 1'b0;
        logic held_v = 1'b0;
        logic [31:0] hy = '0;
        logic [3:0]  ht = '0;
        @(posedge clk); #1;
        dsel = s; in_valid = 1'b0; out_ready = 1'b1;
        while (got < nops && cyc < nops * 4 + 100) begin
            @(posedge clk); #1; cyc++;
            if (held_v) begin
                checks++;
                if (yo !== hy || to !== ht) begin errors++; $display("FAIL %s_hold got %h/%h want %h/%h", nm, yo, to, hy, ht); end
            end
            if (!in_valid || last_acc) begin
                in_valid = 1'b0;
                if (sent < nops && $urandom_range(9) != 0) begin
                    a = 16'($urandom); b = 16'($urandom);
                    mode = (fmode < 0) ? 2'($urandom_range(3)) : 2'(fmode);
                    tag_in = 4'($urandom); in_valid = 1'b1;
                end
            end
            out_ready = ($urandom_range(4) != 0);
            #1;
            checks++;
            if (ir !== !(ov && !out_ready)) begin errors++; $display("FAIL %s_in_ready got %b want %b", nm, ir, !(ov && !out_ready)); end
            last_acc = in_valid && ir;
            if (ov && out_ready) begin
                checks++;
                if (qy.size() == 0) begin
                    errors++; $display("FAIL %s_spurious got %h want none", nm, yo);
                end else begin
                    ey = qy.pop_front(); et = qt.pop_front();
                    if (yo !== ey || to !== et) begin errors++; $display("FAIL %s_result%0d got %h/%h want %h/%h", nm, got, yo, to, ey, et); end
                end
                got++;
            end
            if (last_acc) begin
                qy.push_back(ref_mul(a, b, mode)); qt.push_back(tag_in); sent++;
            end
            held_v = ov && !out_ready; hy = yo; ht = to;
        end
        in_valid = 1'b0;
        checks++; if (got != nops) begin errors++; $display("FAIL %s_count got %0d want %0d", nm, got, nops); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; dsel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; mode = '0; tag_in = '0;
        test_reset();
        test_latency(1'b0, 4, 16'hFFFF, 16'hFFFF, MODE_FULL, 4'd5, 32'hFFFE0001, "full");
        test_latency(1'b0, 4, 16'hFFFF, 16'hFFFF, MODE_LO,   4'd6, 32'h00000001, "lo");
        test_latency(1'b0, 4, 16'hFFFF, 16'hFFFF, MODE_HI,   4'd7, 32'h0000FFFE, "hi");
        test_latency(1'b0, 4, 16'h1234, 16'hDEAD, MODE_SQR,  4'd8, 32'h014B5A90, "sqr");
        test_back_to_back();
        test_reset_midflight();
        test_latency(1'b1, 1, 16'h00FF, 16'h0100, MODE_FULL, 4'd3, 32'h0000FF00, "s1_full");
        test_random(1'b1, 10000, 0, "s1_full_rand");
        test_random(1'b1, 10000, 1, "s1_lo_rand");
        test_random(1'b1, 10000, 2, "s1_hi_rand");
        test_random(1'b1, 10000, 3, "s1_sqr_rand");
        test_random(1'b0, 2000, -1, "s4_rand");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
